// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [31:0] NOP = 32'h0000_0000;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags a load in ID_EX whose destination feeds the instruction in IF_ID
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       i_memread,
  input  logic [4:0] i_ex_rt,
  input  logic [4:0] i_rs,
  input  logic [4:0] i_rt,
  output logic       o_hazard
);
  assign o_hazard = i_memread && (i_ex_rt != REG_ZERO) && (i_ex_rt == i_rs || i_ex_rt == i_rt);
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush controller with data-memory handshake sequencing
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic [4:0]       if_id_rs_i,
  input  logic [4:0]       if_id_rt_i,
  input  logic             id_ex_memread_i,
  input  logic [4:0]       id_ex_rt_i,
  input  logic             branch_taken_i,
  input  logic             ex_mem_memread_i,
  input  logic             ex_mem_memwrite_i,
  input  logic             dmem_ack_i,
  output logic             dmem_req_o,
  output logic             pc_stall_o,
  output logic             if_id_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_stall_o,
  output logic             mem_wb_stall_o,
  output logic [CNT_W-1:0] perf_stall_cnt_o,
  output logic             err_o
);
  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_wait, r_cnt;
  logic             r_err;
  logic             w_memop, w_hazard, w_mem_stall, w_req, w_run_ok, w_lu;

  assign w_memop = ex_mem_memread_i | ex_mem_memwrite_i;

  load_use_detect u_lud (
    .i_memread (id_ex_memread_i),
    .i_ex_rt   (id_ex_rt_i),
    .i_rs      (if_id_rs_i),
    .i_rt      (if_id_rt_i),
    .o_hazard  (w_hazard)
  );

  // next state and memory-stall decision; a same-cycle ack releases the freeze
  always_comb begin
    w_next      = r_state;
    w_mem_stall = 1'b0;
    w_req       = 1'b0;
    case (r_state)
      RUN: begin
        w_req       = w_memop;
        w_mem_stall = w_memop && !dmem_ack_i;
        w_next      = (w_memop && !dmem_ack_i) ? WAIT : RUN;
      end
      WAIT: begin
        w_req       = 1'b1;
        w_mem_stall = !dmem_ack_i;
        w_next      = dmem_ack_i ? RUN : (r_wait == CNT_W'(TIMEOUT)) ? ERR : WAIT;
      end
      ERR: w_mem_stall = 1'b1;
      default: w_next = RUN;
    endcase
  end

  // stall/flush outputs, all forced low while reset is held
  always_comb begin
    w_run_ok       = !rst_i && r_state == RUN && !w_mem_stall;
    w_lu           = w_run_ok && w_hazard;
    dmem_req_o     = !rst_i && w_req;
    pc_stall_o     = (!rst_i && w_mem_stall) || w_lu;
    if_id_stall_o  = (!rst_i && w_mem_stall) || w_lu;
    id_ex_flush_o  = w_lu;
    if_id_flush_o  = w_run_ok && !w_hazard && branch_taken_i;
    ex_mem_stall_o = !rst_i && w_mem_stall;
    mem_wb_stall_o = !rst_i && w_mem_stall;
  end

  // state, wait counter, sticky error and saturating stall counter
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_state <= RUN;
      r_wait  <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_wait  <= (w_next == WAIT) ? ((r_state == WAIT) ? r_wait + CNT_W'(1) : CNT_W'(1)) : '0;
      r_err   <= r_err || w_next == ERR;
      r_cnt   <= (pc_stall_o && r_cnt != '1) ? r_cnt + CNT_W'(1) : r_cnt;
    end
  end

  assign perf_stall_cnt_o = r_cnt;
  assign err_o            = r_err;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random checks of two controller instances against a reference model
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic [4:0] if_id_rs_i = '0, if_id_rt_i = '0, id_ex_rt_i = '0;
  logic id_ex_memread_i = 0, branch_taken_i = 0, ex_mem_memread_i = 0, ex_mem_memwrite_i = 0, dmem_ack_i = 0;
  logic a_req, a_pc, a_ifs, a_iff, a_idf, a_exs, a_mws, a_err;
  logic b_req, b_pc, b_ifs, b_iff, b_idf, b_exs, b_mws, b_err;
  logic [15:0] a_cnt;
  logic [3:0]  b_cnt;
  logic [7:0]  oa, ob;

  int n_assert = 0, n_fail = 0;
  int tmo[2]  = '{4, 6};
  int cmax[2] = '{65535, 15};
  bit m_err[2], m_wait[2];
  int m_waited[2], m_cnt[2];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst_i(rst_i), .if_id_rs_i(if_id_rs_i), .if_id_rt_i(if_id_rt_i),
    .id_ex_memread_i(id_ex_memread_i), .id_ex_rt_i(id_ex_rt_i), .branch_taken_i(branch_taken_i),
    .ex_mem_memread_i(ex_mem_memread_i), .ex_mem_memwrite_i(ex_mem_memwrite_i), .dmem_ack_i(dmem_ack_i),
    .dmem_req_o(a_req), .pc_stall_o(a_pc), .if_id_stall_o(a_ifs), .if_id_flush_o(a_iff),
    .id_ex_flush_o(a_idf), .ex_mem_stall_o(a_exs), .mem_wb_stall_o(a_mws),
    .perf_stall_cnt_o(a_cnt), .err_o(a_err));

  pipe_hazard_ctrl #(.TIMEOUT(6), .CNT_W(4)) dut_b (
    .clk(clk), .rst_i(rst_i), .if_id_rs_i(if_id_rs_i), .if_id_rt_i(if_id_rt_i),
    .id_ex_memread_i(id_ex_memread_i), .id_ex_rt_i(id_ex_rt_i), .branch_taken_i(branch_taken_i),
    .ex_mem_memread_i(ex_mem_memread_i), .ex_mem_memwrite_i(ex_mem_memwrite_i), .dmem_ack_i(dmem_ack_i),
    .dmem_req_o(b_req), .pc_stall_o(b_pc), .if_id_stall_o(b_ifs), .if_id_flush_o(b_iff),
    .id_ex_flush_o(b_idf), .ex_mem_stall_o(b_exs), .mem_wb_stall_o(b_mws),
    .perf_stall_cnt_o(b_cnt), .err_o(b_err));

  assign oa = {a_req, a_pc, a_ifs, a_iff, a_idf, a_exs, a_mws, a_err};
  assign ob = {b_req, b_pc, b_ifs, b_iff, b_idf, b_exs, b_mws, b_err};

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_err[k] = 0; m_wait[k] = 0; m_waited[k] = 0; m_cnt[k] = 0;
    end
  endfunction

  // expected {req, pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall, mem_wb_stall, err}
  function automatic logic [7:0] model_out(int k);
    bit memop, st, lu, br, req;
    if (rst_i) return 8'h00;
    if (m_err[k]) return 8'b0110_0111;
    memop = ex_mem_memread_i || ex_mem_memwrite_i;
    req = m_wait[k] || memop;
    st  = req && !dmem_ack_i;
    lu  = !m_wait[k] && !st && id_ex_memread_i && id_ex_rt_i != 0 &&
          (id_ex_rt_i == if_id_rs_i || id_ex_rt_i == if_id_rt_i);
    br  = !m_wait[k] && !st && !lu && branch_taken_i;
    return {req, st | lu, st | lu, br, lu, st, st, 1'b0};
  endfunction

  task automatic check_all();
    logic [7:0] exp_o, obs_o;
    int obs_c;
    if (rst_i) model_reset();
    for (int k = 0; k < 2; k++) begin
      exp_o = model_out(k);
      obs_o = (k == 0) ? oa : ob;
      obs_c = (k == 0) ? int'(a_cnt) : int'(b_cnt);
      n_assert++;
      assert (obs_o === exp_o) else begin
        n_fail++;
        $error("FAIL ctl%0d t=%0t observed=%b expected=%b", k, $time, obs_o, exp_o);
      end
      n_assert++;
      assert (obs_c === m_cnt[k]) else begin
        n_fail++;
        $error("FAIL cnt%0d t=%0t observed=%0d expected=%0d", k, $time, obs_c, m_cnt[k]);
      end
    end
  endtask

  task automatic update_model();
    logic [7:0] o;
    if (rst_i) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      o = model_out(k);
      if (o[6] && m_cnt[k] < cmax[k]) m_cnt[k]++;
      if (m_err[k]) begin
      end else if (m_wait[k]) begin
        if (dmem_ack_i) m_wait[k] = 0;
        else if (m_waited[k] == tmo[k]) begin m_err[k] = 1; m_wait[k] = 0; end
        else m_waited[k]++;
      end else if ((ex_mem_memread_i || ex_mem_memwrite_i) && !dmem_ack_i) begin
        m_wait[k] = 1; m_waited[k] = 1;
      end
    end
  endtask

  task automatic step(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_all();
      @(posedge clk);
      update_model();
      #1;
    end
  endtask

  task automatic clear_in();
    if_id_rs_i = 0; if_id_rt_i = 0; id_ex_rt_i = 0; id_ex_memread_i = 0;
    branch_taken_i = 0; ex_mem_memread_i = 0; ex_mem_memwrite_i = 0; dmem_ack_i = 0;
  endtask

  initial begin
    model_reset();
    step(2);
    rst_i = 0;
    step(1);
    id_ex_memread_i = 1; id_ex_rt_i = 5; if_id_rs_i = 5;
    step(1);
    id_ex_rt_i = 0; if_id_rs_i = 0;
    step(1);
    id_ex_rt_i = 7; if_id_rt_i = 7; branch_taken_i = 1;
    step(1);
    id_ex_memread_i = 0;
    step(1);
    clear_in();
    ex_mem_memread_i = 1;
    step(3);
    dmem_ack_i = 1;
    step(1);
    step(1);
    clear_in();
    ex_mem_memread_i = 1; branch_taken_i = 1;
    step(2);
    dmem_ack_i = 1;
    step(1);
    clear_in();
    ex_mem_memread_i = 1;
    step(3);
    #1 rst_i = 1;
    step(1);
    rst_i = 0; clear_in();
    step(1);
    ex_mem_memwrite_i = 1;
    step(10);
    clear_in(); branch_taken_i = 1;
    step(2);
    rst_i = 1;
    step(1);
    rst_i = 0; clear_in();
    id_ex_memread_i = 1; id_ex_rt_i = 3; if_id_rs_i = 3;
    step(20);
    clear_in();
    step(1);
    for (int i = 0; i < 400; i++) begin
      rst_i = ($urandom_range(0, 39) == 0);
      if_id_rs_i = 5'($urandom_range(0, 7));
      if_id_rt_i = 5'($urandom_range(0, 7));
      id_ex_rt_i = 5'($urandom_range(0, 7));
      id_ex_memread_i = 1'($urandom_range(0, 1));
      branch_taken_i = 1'($urandom_range(0, 1));
      ex_mem_memread_i = ($urandom_range(0, 3) == 0);
      ex_mem_memwrite_i = ($urandom_range(0, 5) == 0);
      dmem_ack_i = ($urandom_range(0, 2) == 0);
      step(1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline; drives the stall_i/flush inputs of PC, IF_ID, ID_EX, EX_MEM and MEM_WB.
- Detects load-use hazards and taken branches resolved in ID.
- Sequences multi-cycle data-memory accesses through a req/ack handshake, freezing the whole pipeline until the access completes.
- Keeps a saturating stall-cycle counter and a sticky memory-timeout error.

Parameters:
- TIMEOUT, 64: maximum WAIT cycles without dmem_ack_i before the access is aborted; legal range 1..2^CNT_W-1.
- CNT_W, 16: width of perf_stall_cnt_o and of the internal wait counter.

Ports:
- clk  input  1  clock, rising edge
- rst_i  input  1  asynchronous active-high reset
- if_id_rs_i  input  5  rs field of the instruction in IF_ID
- if_id_rt_i  input  5  rt field of the instruction in IF_ID
- id_ex_memread_i  input  1  instruction in ID_EX is a load
- id_ex_rt_i  input  5  destination register of the load in ID_EX
- branch_taken_i  input  1  branch in ID resolved taken
- ex_mem_memread_i  input  1  instruction in EX_MEM reads data memory
- ex_mem_memwrite_i  input  1  instruction in EX_MEM writes data memory
- dmem_ack_i  input  1  data memory completes the current request this cycle
- dmem_req_o  output  1  data memory request strobe
- pc_stall_o  output  1  hold PC
- if_id_stall_o  output  1  hold IF_ID
- if_id_flush_o  output  1  load NOP into IF_ID
- id_ex_flush_o  output  1  load a bubble (all controls 0) into ID_EX
- ex_mem_stall_o  output  1  hold EX_MEM
- mem_wb_stall_o  output  1  hold MEM_WB
- perf_stall_cnt_o  output  CNT_W  count of cycles with pc_stall_o=1, saturating
- err_o  output  1  sticky memory-timeout error

Behaviour:
- FSM states: RUN, WAIT, ERR. Reset (async, rst_i=1) forces RUN, clears the wait counter, perf_stall_cnt_o=0 and err_o=0.
- While rst_i=1, all stall, flush and request outputs are 0.
- Let memop = ex_mem_memread_i | ex_mem_memwrite_i.
- RUN with memop=1:
  - dmem_req_o=1.
  - If dmem_ack_i=1 in the same cycle, the access is zero-wait: no memory stall, remain in RUN.
  - Otherwise assert all five stalls, suppress both flushes, and go to WAIT with the wait counter at 1.
- WAIT:
  - dmem_req_o stays 1; the pipeline input signals are frozen by the stalls.
  - On dmem_ack_i=1: deassert all stalls in that same cycle (combinational ack path) and return to RUN. The instruction advances to MEM_WB at the next edge.
  - Without ack: hold all stalls and increment the wait counter.
  - When the counter reaches TIMEOUT with no ack: next state ERR, err_o=1.
- ERR: dmem_req_o=0, all five stalls held at 1, flushes 0. Exit only via reset.
- Load-use (RUN, no memory stall): condition is id_ex_memread_i=1, id_ex_rt_i != 0, and id_ex_rt_i equals if_id_rs_i or if_id_rt_i.
  - Response: pc_stall_o=1, if_id_stall_o=1, id_ex_flush_o=1 for exactly that cycle.
  - EX_MEM and MEM_WB keep advancing.
- Branch (RUN, no memory stall, no load-use): branch_taken_i=1 gives if_id_flush_o=1 for one cycle; PC not stalled.
- Priority: memory stall > load-use > branch flush. Flushes are never asserted while the matching register is stalled.
- perf_stall_cnt_o increments on every edge where pc_stall_o=1 and saturates at all-ones.
- Reset asserted mid-WAIT abandons the request: dmem_req_o drops immediately and no ack is expected afterwards.
- Stall and flush outputs are combinational from state and inputs; state, counters and err_o are registered.

Decomposition:
- Shared package pipe_ctrl_pkg: state enum (RUN/WAIT/ERR), REG_ZERO=5'd0, NOP instruction constant.
- One natural sub-module: load_use_detect, a combinational comparator producing a hazard flag from the IF_ID/ID_EX fields.

Test Plan:
- Reset mid-WAIT (memread=1, no ack, 3 cycles, then rst_i=1): all outputs 0 immediately; after release, RUN with cnt=0 and err_o=0.
- Load-use (id_ex_memread=1, id_ex_rt=5, if_id_rs=5): one cycle of pc_stall/if_id_stall/id_ex_flush=1; the same case with rt=0 gives no stall.
- Load-use plus branch_taken_i=1 in the same cycle: only the load-use response; if_id_flush_o=0; the flush appears the next cycle if the branch is still taken.
- Memory read acked after 3 cycles: all stalls=1 for 3 cycles, released in the ack cycle; perf_stall_cnt_o=3; a zero-wait ack gives no stall.
- memwrite with TIMEOUT=4 and no ack: after 4 WAIT cycles, err_o=1, dmem_req_o=0, stalls remain 1 until reset.
- Memory stall concurrent with branch_taken_i=1: if_id_flush_o=0 throughout the stall.
- Saturation: with CNT_W=4, force 20 stall cycles: perf_stall_cnt_o holds at 15.
